// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared constants and types for the pipeline hazard controller.
//   FWD_RF/FWD_WB/FWD_MEM : 2-bit execute-stage operand-select encodings.
//   md_state_t            : state of the MDU in-flight tracker.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage : hazard_pkg

// File: rtl/md_busy_tracker.sv
// md_busy_tracker
//   Tracks one in-flight multi-cycle MDU operation. A start pulse in IDLE
//   loads a countdown with MD_LAT-1; the tracker stays BUSY until the count
//   reaches 1, so busy_o is high for exactly MD_LAT-1 cycles.
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   MDU op issued this cycle (ignored while BUSY)
//   busy_o   out  MDU op in flight (registered)
//   state_o  out  current FSM state, for observation
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      start_i,
  output logic      busy_o,
  output md_state_t state_o
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        // A start here cannot be legal: the decode stall blocks issue.
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o  = (state_q == MD_BUSY);
    state_o = state_q;
  end

endmodule : md_busy_tracker

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Stall/flush/forward control for a 5-stage pipeline. Detects load-use,
//   branch-operand and MDU-busy hazards and produces forwarding selects for
//   the execute and decode stages. All outputs except MdBusy are
//   combinational from inputs and tracker state.
// Handshake: none; every control is a level valid for the current cycle.
// Optional feature: HAZARD_PERF_EN adds saturating StallCnt/FlushCnt.
// Ports
//   CLK, RST                     clock / async active-low reset
//   RsD, RtD, RsE, RtE           source register indices (decode / execute)
//   WriteRegE/M/W, RegWriteE/M/W destination index and write enable per stage
//   MemtoRegE/M                  load in execute / memory
//   BranchD, PCSrcD              branch in decode / branch taken
//   MdStartE, MdUseD             MDU issue in E / decode needs MDU result
//   StallF, StallD, FlushD, FlushE   pipeline register controls
//   ForwardAE/BE (2b), ForwardAD/BD  forwarding selects
//   StallCnt, FlushCnt           perf counters (HAZARD_PERF_EN only)
//   MdBusy                       MDU op in flight
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR = 5,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [REG_ADDR-1:0] RsD,
  input  logic [REG_ADDR-1:0] RtD,
  input  logic [REG_ADDR-1:0] RsE,
  input  logic [REG_ADDR-1:0] RtE,
  input  logic [REG_ADDR-1:0] WriteRegE,
  input  logic [REG_ADDR-1:0] WriteRegM,
  input  logic [REG_ADDR-1:0] WriteRegW,
  input  logic                RegWriteE,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic                MemtoRegE,
  input  logic                MemtoRegM,
  input  logic                BranchD,
  input  logic                PCSrcD,
  input  logic                MdStartE,
  input  logic                MdUseD,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                ForwardAD,
  output logic                ForwardBD,
`ifdef HAZARD_PERF_EN
  output logic [31:0]         StallCnt,
  output logic [31:0]         FlushCnt,
`endif
  output logic                MdBusy
);

  // Register 0 is hard-wired zero, so it never produces a dependency.
  function automatic logic hit(input logic we,
                               input logic [REG_ADDR-1:0] dst,
                               input logic [REG_ADDR-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  md_state_t md_state;
  logic      lwstall, brstall, mdstall, stall_raw, stall;

  md_busy_tracker #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_busy (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .start_i (MdStartE),
    .busy_o  (MdBusy),
    .state_o (md_state)
  );

  always_comb begin
    lwstall   = hit(MemtoRegE, RtE, RsD) || hit(MemtoRegE, RtE, RtD);
    brstall   = BranchD && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD) ||
                            hit(MemtoRegM, WriteRegM, RsD) || hit(MemtoRegM, WriteRegM, RtD));
    mdstall   = MdBusy && MdUseD;
    stall_raw = lwstall || brstall || mdstall;
    // Stall/flush controls are forced low while reset is asserted.
    stall     = RST && stall_raw;
    StallF    = stall;
    StallD    = stall;
    FlushE    = stall;
    // A stalled branch still has stale operands, so it must not redirect yet.
    FlushD    = RST && PCSrcD && !stall_raw;
  end

  // Forwarding: the memory stage holds the younger value, so it wins.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (hit(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_MEM;
    else if (hit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_WB;
    if (hit(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_MEM;
    else if (hit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_WB;
    ForwardAD = hit(RegWriteM, WriteRegM, RsD);
    ForwardBD = hit(RegWriteM, WriteRegM, RtD);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Directed plus small randomized checks of hazard_ctrl_unit.
//   Observed vector: {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,
//                     ForwardAD,ForwardBD,MdBusy} (11 bits).
//   Perf-counter checks compile only with HAZARD_PERF_EN.
module tb_hazard_ctrl_unit;

  localparam int W = 11;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, MdStartE, MdUseD;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  hazard_ctrl_unit #(.REG_ADDR(5), .MD_LAT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MdStartE(MdStartE), .MdUseD(MdUseD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef HAZARD_PERF_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .MdBusy(MdBusy)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; MdStartE = 0; MdUseD = 0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [W-1:0] ev(input logic st, input logic fd,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic fad, input logic fbd, input logic mb);
    return {st, st, fd, st, fae, fbe, fad, fbd, mb};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic expect_out(input string tag, input logic [W-1:0] e);
    logic [W-1:0] got, want;
    exp_q.push_back(e);
    #1;
    got  = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic expect_cnt(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask
`endif

  // Independent forwarding reference for randomized checks.
  function automatic logic [1:0] fwd_ref(input logic [4:0] s);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == s) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == s) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic fad_e, fbd_e;
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);

    // Reset state, then hazard inputs while still in reset
    expect_out("reset_idle", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    MemtoRegE = 1; RtE = 8; RsD = 8; PCSrcD = 1;
    RegWriteM = 1; WriteRegM = 5; RsE = 5;
    expect_out("reset_gates_stall", ev(0, 0, 2'b10, 2'b00, 0, 0, 0));
    clear_inputs();
    RST = 1'b1;
    step();

    // 1. load-use
    MemtoRegE = 1; RtE = 8; RsD = 8;
    expect_out("lw_stall", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));
    step();
    clear_inputs();
    RsE = 8; RegWriteM = 1; WriteRegM = 8;
    expect_out("lw_after_fwd", ev(0, 0, 2'b10, 2'b00, 0, 0, 0));
    step();
    clear_inputs();
    MemtoRegE = 1; RtE = 0; RsD = 0;
    expect_out("lw_reg0", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    clear_inputs();

    // 2. forwarding priority and zero register
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    expect_out("fwd_mem_wins", ev(0, 0, 2'b10, 2'b10, 0, 0, 0));
    RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0;
    expect_out("fwd_reg0", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    RegWriteM = 0; WriteRegW = 5; RsE = 5; RtE = 6;
    expect_out("fwd_wb", ev(0, 0, 2'b01, 2'b00, 0, 0, 0));
    clear_inputs();
    RegWriteM = 1; WriteRegM = 7; RsD = 7; RtD = 7;
    expect_out("fwd_decode", ev(0, 0, 2'b00, 2'b00, 1, 1, 0));
    clear_inputs();

    // 3. branch hazards
    BranchD = 1; PCSrcD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    expect_out("br_stall_e", ev(1, 0, 2'b00, 2'b00, 0, 0, 0));
    clear_inputs();
    BranchD = 1; PCSrcD = 1; RtD = 4; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4;
    expect_out("br_stall_m", ev(1, 0, 2'b00, 2'b00, 0, 1, 0));
    clear_inputs();
    BranchD = 1; PCSrcD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 9;
    expect_out("br_taken_flush", ev(0, 1, 2'b00, 2'b00, 0, 0, 0));
    clear_inputs();
    BranchD = 1; RsD = 0; RegWriteE = 1; WriteRegE = 0;
    expect_out("br_reg0", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    clear_inputs();
    step();

    // 4. MDU busy window
    MdStartE = 1; MdUseD = 1;
    expect_out("md_start", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    step();
    MdStartE = 0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("md_busy_%0d", i), ev(1, 0, 2'b00, 2'b00, 0, 0, 1));
      step();
    end
    expect_out("md_done", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    MdUseD = 0;
    expect_out("md_busy_no_use", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    MdStartE = 1;
    step();
    MdStartE = 0;
    expect_out("md_busy_nouse", ev(0, 0, 2'b00, 2'b00, 0, 0, 1));
    step(); step(); step();
    clear_inputs();

    // 5. reset mid-op
    MdStartE = 1; MdUseD = 1;
    step();
    MdStartE = 0;
    expect_out("md_rst_c1", ev(1, 0, 2'b00, 2'b00, 0, 0, 1));
    step();
    RST = 1'b0;
    expect_out("md_rst_async", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    step();
    RST = 1'b1;
    expect_out("md_rst_release", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    step();
    expect_out("md_rst_after", ev(0, 0, 2'b00, 2'b00, 0, 0, 0));
    clear_inputs();

    // Randomized forwarding
    for (int i = 0; i < 24; i++) begin
      RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
      RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
      WriteRegE = 5'($urandom_range(0, 7));
      WriteRegM = 5'($urandom_range(0, 7)); WriteRegW = 5'($urandom_range(0, 7));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      fad_e = RegWriteM && WriteRegM != 0 && WriteRegM == RsD;
      fbd_e = RegWriteM && WriteRegM != 0 && WriteRegM == RtD;
      expect_out($sformatf("rnd_fwd_%0d", i),
                 ev(0, 0, fwd_ref(RsE), fwd_ref(RtE), fad_e, fbd_e, 0));
      step();
    end
    clear_inputs();

`ifdef HAZARD_PERF_EN
    // 6. performance counters
    RST = 1'b0;
    step();
    RST = 1'b1;
    expect_cnt("perf_reset_stall", StallCnt, 32'd0);
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step(); step(); step();
    clear_inputs();
    PCSrcD = 1;
    step();
    clear_inputs();
    step();
    expect_cnt("perf_stall_cnt", StallCnt, 32'd3);
    expect_cnt("perf_flush_cnt", FlushCnt, 32'd1);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step();
    clear_inputs();
    expect_cnt("perf_stall_sat", StallCnt, 32'hFFFF_FFFF);
`endif

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit
